// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : encoding of the op_i select (MULT, MULTU, DIV, DIVU)
//   - mdu_state_e : control FSM states
//   - MDU_WIDTH   : default operand width (also the iteration count)
//   - helpers     : decode of the signed / divide attributes of an op
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration.
// Ports:
//   rem_quot_in  in  2*WIDTH  {partial remainder, remaining dividend / quotient bits}
//   divisor      in  WIDTH    divisor magnitude
//   rem_quot_out out 2*WIDTH  {next remainder, quotient with new bit shifted in}
// The dividend bits are consumed from the top of the low half while quotient
// bits enter at the bottom, so the low half is shared by both.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] rem_quot_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_quot_out
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             take;

  always_comb begin
    rem_shift = {rem_quot_in[2*WIDTH-1:WIDTH], rem_quot_in[WIDTH-1]};
    take      = (rem_shift >= {1'b0, divisor});
    // When take is set the true difference is below divisor, so the low
    // WIDTH bits of a modulo-2^WIDTH subtraction are exact.
    diff      = rem_shift[WIDTH-1:0] - divisor;
    if (take) begin
      rem_quot_out = {diff, rem_quot_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_quot_out = {rem_shift[WIDTH-1:0], rem_quot_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i, op_i, src1_i, src2_i : launch an operation (IDLE or DONE only)
//   hi_we_i, lo_we_i              : MTHI/MTLO writes of src1_i (IDLE or DONE only)
//   abort_i                       : cancel an operation in RUN
//   busy_o, done_o, div_zero_o    : status (all registered)
//   hi_o, lo_o                    : architectural HI/LO
// One iteration per cycle for WIDTH cycles over a shared 2*WIDTH accumulator
// holding the product (multiply) or {remainder, quotient} (divide).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_reg, state_next;
  mdu_op_e            op_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;      // multiplicand or divisor magnitude
  logic               neg_a_reg, neg_b_reg, div_zero_reg;
  logic               div_zero_out_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  mdu_op_e            op_in;
  logic               accept, last;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc, div_acc, step_acc, prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_quot_in  (acc_reg),
    .divisor      (opnd_reg),
    .rem_quot_out (div_acc)
  );

  // Launch-time decode: signed ops work on magnitudes; |MIN| == MIN as unsigned.
  always_comb begin
    op_in    = mdu_op_e'(op_i);
    accept   = start_i && (state_reg != RUN);
    last     = (count_reg == CW'(WIDTH - 1));
    neg_a_in = op_is_signed(op_in) && src1_i[WIDTH-1];
    neg_b_in = op_is_signed(op_in) && src2_i[WIDTH-1];
    mag_a_in = neg_a_in ? -src1_i : src1_i;
    mag_b_in = neg_b_in ? -src2_i : src2_i;
  end

  // Shift-add multiply: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator right, keeping the carry-out.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg & {WIDTH{acc_reg[0]}}};
    mul_acc  = {mul_sum, acc_reg[WIDTH-1:1]};
    step_acc = op_is_div(op_reg) ? div_acc : mul_acc;

    // Sign fix-up on the final step result. Sign flags are only ever set for
    // signed ops, so unsigned ops pass through untouched.
    prod = (neg_a_reg ^ neg_b_reg) ? -step_acc : step_acc;
    quot = step_acc[WIDTH-1:0];
    rem  = step_acc[2*WIDTH-1:WIDTH];
    if (op_is_div(op_reg)) begin
      // With a zero divisor the restoring loop leaves the dividend magnitude
      // in the remainder, so the normal remainder fix-up restores src1 as given.
      res_lo = div_zero_reg ? '1 : ((neg_a_reg ^ neg_b_reg) ? -quot : quot);
      res_hi = neg_a_reg ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_i) state_next = RUN;
      RUN: begin
        if (abort_i)   state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = start_i ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_reg           <= MDU_MULT;
      count_reg        <= '0;
      acc_reg          <= '0;
      opnd_reg         <= '0;
      neg_a_reg        <= 1'b0;
      neg_b_reg        <= 1'b0;
      div_zero_reg     <= 1'b0;
      div_zero_out_reg <= 1'b0;
      hi_reg           <= '0;
      lo_reg           <= '0;
    end else begin
      div_zero_out_reg <= 1'b0;
      if (accept) begin
        // Start wins over a simultaneous MTHI/MTLO.
        op_reg       <= op_in;
        count_reg    <= '0;
        neg_a_reg    <= neg_a_in;
        neg_b_reg    <= neg_b_in;
        div_zero_reg <= op_is_div(op_in) && (src2_i == '0);
        opnd_reg     <= op_is_div(op_in) ? mag_b_in : mag_a_in;
        acc_reg      <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? mag_a_in : mag_b_in)};
      end else if (state_reg == RUN) begin
        if (!abort_i) begin
          count_reg <= count_reg + CW'(1);
          acc_reg   <= step_acc;
          if (last) begin
            hi_reg           <= res_hi;
            lo_reg           <= res_lo;
            div_zero_out_reg <= div_zero_reg;
          end
        end
      end else begin
        if (hi_we_i) hi_reg <= src1_i;
        if (lo_we_i) lo_reg <= src1_i;
      end
    end
  end

  assign busy_o     = (state_reg == RUN);
  assign done_o     = (state_reg == DONE);
  assign div_zero_o = div_zero_out_reg;
  assign hi_o       = hi_reg;
  assign lo_o       = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: arithmetic results with hand-computed
// expectations, latency/handshake timing, MTHI/MTLO, abort and async reset.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, hi_we_i, lo_we_i, abort_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .hi_we_i    (hi_we_i),
    .lo_we_i    (lo_we_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op and hold start_i across one rising edge (E0). With now=1 the
  // inputs are driven immediately (used from inside a DONE cycle).
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit now);
    if (!now) @(negedge clk_i);
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Watch the run on falling edges until done_o; optionally pulse start_i
  // during RUN at falling edge index glitch_at. Returns in the DONE cycle.
  task automatic wait_done(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz, input int glitch_at);
    int nb  = 0;
    int cyc = -1;
    bit got = 0;
    bit ovl = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (busy_o) nb++;
      if (busy_o && done_o) ovl = 1;
      if (done_o) begin
        got = 1;
        cyc = i;
      end else if (i == glitch_at) begin
        start_i = 1'b1;
        op_i    = OP_MULTU;
        src1_i  = 32'h0000_DEAD;
        src2_i  = 32'h0000_0000;
      end
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_busy_done_overlap"}, 64'(ovl), 64'd0);
    chk({tag, "_hi"}, 64'(hi_o), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(elo));
    chk({tag, "_div_zero"}, 64'(div_zero_o), 64'(edz));
    $display("txn %s hi=0x%08h lo=0x%08h dz=%0d latency=%0d", tag, hi_o, lo_o, div_zero_o, cyc);
  endtask

  initial begin
    int pulses;
    rst_i   = 1'b0;
    start_i = 1'b0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    abort_i = 1'b0;
    op_i    = 2'd0;
    src1_i  = '0;
    src2_i  = '0;

    #2;
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_dz", 64'(div_zero_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
    @(negedge clk_i);
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("idle_after_done_busy", 64'(busy_o), 64'd0);

    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    wait_done("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
    launch(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    wait_done("mult_minxmin", 32'h4000_0000, 32'h0000_0000, 1'b0, -1);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    wait_done("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    launch(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    wait_done("div_7_neg2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -1);
    launch(OP_DIVU, 32'h0000_0007, 32'h0000_0002, 0);
    wait_done("divu_7_2", 32'h0000_0001, 32'h0000_0003, 1'b0, -1);
    launch(OP_DIV, 32'h1234_5678, 32'h0000_0000, 0);
    wait_done("div_by_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, -1);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 0);
    wait_done("div_neg_by_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, -1);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_done("div_min_neg1", 32'h0000_0000, 32'h8000_0000, 1'b0, -1);

    // start_i pulsed in the middle of RUN must be ignored.
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 0);
    wait_done("start_in_run", 32'h0000_0001, 32'h0000_0000, 1'b0, 5);

    // Back-to-back issue from the DONE cycle.
    launch(OP_DIVU, 32'd100, 32'd7, 0);
    wait_done("b2b_first", 32'd2, 32'd14, 1'b0, -1);
    launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done("b2b_second", 32'h0000_0000, 32'h0000_0001, 1'b0, -1);

    // MTLO / MTHI in IDLE.
    @(negedge clk_i);
    lo_we_i = 1'b1;
    src1_i  = 32'hA5A5_A5A5;
    @(posedge clk_i);
    #1 lo_we_i = 1'b0;
    @(negedge clk_i);
    chk("mtlo_lo", 64'(lo_o), 64'hA5A5_A5A5);
    chk("mtlo_hi_kept", 64'(hi_o), 64'h0);
    hi_we_i = 1'b1;
    src1_i  = 32'h5A5A_5A5A;
    @(posedge clk_i);
    #1 hi_we_i = 1'b0;
    @(negedge clk_i);
    chk("mthi_hi", 64'(hi_o), 64'h5A5A_5A5A);
    $display("txn mthi_mtlo hi=0x%08h lo=0x%08h", hi_o, lo_o);

    // Abort at RUN cycle 10: HI/LO keep their values and no done pulse follows.
    launch(OP_DIVU, 32'd100, 32'd3, 0);
    for (int i = 0; i < 10; i++) @(negedge clk_i);
    abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_hi", 64'(hi_o), 64'h5A5A_5A5A);
    chk("abort_lo", 64'(lo_o), 64'hA5A5_A5A5);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    $display("txn abort hi=0x%08h lo=0x%08h done_pulses=%0d", hi_o, lo_o, pulses);

    // Asynchronous reset mid-RUN, observed before the next rising edge.
    launch(OP_MULTU, 32'd3, 32'd5, 0);
    repeat (8) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midreset_hi", 64'(hi_o), 64'd0);
    chk("midreset_lo", 64'(lo_o), 64'd0);
    chk("midreset_busy", 64'(busy_o), 64'd0);
    chk("midreset_done", 64'(done_o), 64'd0);
    chk("midreset_dz", 64'(div_zero_o), 64'd0);
    $display("txn midreset hi=0x%08h lo=0x%08h busy=%0d", hi_o, lo_o, busy_o);
    @(negedge clk_i);
    rst_i = 1'b1;
    launch(OP_DIVU, 32'd7, 32'd2, 0);
    wait_done("after_reset", 32'd1, 32'd3, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit sitting beside the ALU in the execute stage. It takes the same rs/rt operands the ALU receives and executes MULT, MULTU, DIV and DIVU over multiple cycles. It holds the architectural HI/LO registers read by MFHI/MFLO. While busy, it raises a busy flag that the hazard logic uses to stall the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  launch an operation; accepted only in IDLE or DONE.
- op_i  in  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- src1_i  in  WIDTH  rs operand: multiplicand or dividend; also the MTHI/MTLO data.
- src2_i  in  WIDTH  rt operand: multiplier or divisor.
- hi_we_i  in  1  MTHI: write src1_i into HI.
- lo_we_i  in  1  MTLO: write src1_i into LO.
- abort_i  in  1  pipeline flush; cancels an operation in RUN.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse in DONE.
- div_zero_o  out  1  high with done_o when a DIV/DIVU had src2 == 0.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

## Operation
States:
- IDLE
  - start_i: latch op and operand magnitudes plus sign flags; count = 0; go to RUN.
- RUN
  - One shift-add step (multiply) or one restoring subtract-shift step (divide) per cycle.
  - count increments each step.
  - On the step with count == WIDTH-1: apply sign fix-up, write HI/LO, go to DONE.
- DONE
  - done_o = 1 for this cycle only.
  - start_i here goes straight to RUN (back-to-back issue); otherwise go to IDLE.

Arithmetic:
- Signed ops work on absolute values held as unsigned WIDTH-bit magnitudes. |0x80000000| = 0x80000000.
- MULT/MULTU: the 64-bit product goes to {HI, LO}. For MULT, the product is negated in 64 bits if the operand signs differ.
- DIV/DIVU: quotient goes to LO, remainder to HI.
- DIV sign rules: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Divide by zero: the full latency is still taken. Result is LO = 32'hFFFF_FFFF and HI = src1_i (as latched); div_zero_o = 1 during DONE.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no trap.

MTHI/MTLO:
- Honoured in IDLE and DONE; they take effect on the next edge.
- Ignored in RUN.
- If asserted together with start_i, start wins and the write is dropped.

Boundary conditions:
- start_i during RUN: ignored.
- abort_i during RUN: go to IDLE on the next edge; HI/LO unchanged; no done_o.
- abort_i in IDLE or DONE: no effect.
- rst_i low at any time: immediately go to IDLE with count = 0; HI, LO, busy_o, done_o and div_zero_o all 0.

## Timing
- start_i is sampled at edge E0; busy_o is high from E0 through E32 (32 cycles).
- HI/LO are written at edge E32; done_o and div_zero_o are valid in the cycle after E32.
- hi_o/lo_o show the new result from that same cycle. Total latency is 32 cycles from acceptance to result-visible.
- busy_o and done_o are never high in the same cycle.
- Back-to-back: start_i in the DONE cycle begins the next operation with no idle gap.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mdu_pkg holds:
  - the op_i encoding enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant.
- Sub-module mdu_div_step: purely combinational restoring-division step taking {rem, quotient} and divisor, returning the next {rem, quotient}. It keeps the iteration datapath testable in isolation.
- Single shared WIDTH*2-bit accumulator register: the product for multiply, {rem, quotient} for divide.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. done_o is high exactly in the cycle after E32; busy_o is high for 32 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 -> LO = 3, HI = 1.
- DIV 0x12345678 / 0 -> LO = 0xFFFFFFFF, HI = 0x12345678, div_zero_o = 1 with done_o. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Control:
  - start_i pulsed at cycle 5 of RUN: no effect on result or latency.
  - start_i in the DONE cycle: a second op completes 32 cycles later.
  - MTLO 0xA5A5A5A5 in IDLE: lo_o = 0xA5A5A5A5.
- Interruptions:
  - abort_i at RUN cycle 10: IDLE next cycle, HI/LO retain their prior values, no done_o.
  - rst_i low mid-RUN: all outputs 0 before the next clock edge; after release, the unit is IDLE and accepts start_i.
